// File: rtl/mem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_ctrl
// Purpose  : Request controller in front of the 1024x32 memory. Host commands
//            are queued in a small FIFO and issued to the memory one at a
//            time as single-cycle valid pulses. The controller then waits for
//            the memory's ready pulse, bounded by a timeout, and returns one
//            response per command on a valid/ready channel. Error responses
//            are counted in a saturating 16-bit counter.
// Ports    : clk, rst                      - clock, async active-high reset
//            cmd_valid/cmd_ready           - host command handshake
//            cmd_wr/cmd_addr/cmd_wdata     - host command payload
//            rsp_valid/rsp_ready           - host response handshake
//            rsp_rdata/rsp_err/rsp_timeout - response payload
//            mem_valid/mem_wr_rd/mem_addr/mem_wdata - memory request
//            mem_ready/mem_rdata/mem_error - memory completion
//            err_cnt                       - saturating error-response count
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              mem_valid,
    output logic              mem_wr_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_error,
    output logic [15:0]       err_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_TMR_W = $clog2(TIMEOUT);
    localparam int c_ENT_W = 1 + ADDR_W + DATA_W;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_CNT_FULL = (c_PTR_W + 1)'(DEPTH);
    localparam logic [15:0]        c_ERR_MAX  = 16'hFFFF;

    // Command FIFO
    logic [c_ENT_W-1:0] r_fifo [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    // FSM, timer, issue and response registers
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_mem_wr;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_err;
    logic               r_rsp_to;
    logic [15:0]        r_err_cnt;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_rsp_done;

    assign w_full     = (r_count == c_CNT_FULL);
    assign w_empty    = (r_count == '0);
    // When full, cmd_ready is low, so a same-cycle pop cannot make room for a push.
    assign w_push     = cmd_valid && !w_full;
    assign w_pop      = (r_state == c_IDLE) && !w_empty;
    assign w_rsp_done = (r_state == c_RESP) && rsp_ready;

    // FIFO storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {cmd_wr, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (!w_empty) w_state_nxt = c_ISSUE;
            c_ISSUE: w_state_nxt = c_WAIT;
            // mem_ready takes priority over an expiring timer.
            c_WAIT:  if (mem_ready || (r_timer == c_TMR_LAST)) w_state_nxt = c_RESP;
            c_RESP:  if (rsp_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer     <= '0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_to    <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            // Issue registers change only on a pop, so the memory request
            // fields hold their last values outside ISSUE.
            if (w_pop) begin
                {r_mem_wr, r_mem_addr, r_mem_wdata} <= r_fifo[r_rd_ptr];
            end

            if (r_state == c_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == c_WAIT) begin
                r_timer <= r_timer + c_TMR_ONE;
            end

            // mem_ready is sampled only in WAIT; stray or late pulses fall through.
            if (r_state == c_WAIT) begin
                if (mem_ready) begin
                    r_rsp_rdata <= (!r_mem_wr && !mem_error) ? mem_rdata : '0;
                    r_rsp_err   <= mem_error;
                    r_rsp_to    <= 1'b0;
                end else if (r_timer == c_TMR_LAST) begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b1;
                    r_rsp_to    <= 1'b1;
                end
            end

            if (w_rsp_done && r_rsp_err && (r_err_cnt != c_ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign cmd_ready   = !w_full;
    assign mem_valid   = (r_state == c_ISSUE);
    assign mem_wr_rd   = r_mem_wr;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign rsp_valid   = (r_state == c_RESP);
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_to;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Request controller directly upstream of the 1024x32 memory; owns the memory's valid/ready request port.
- Buffers host commands in a small FIFO and issues them to the memory one at a time, as single-cycle valid pulses.
- Waits for the memory's ready pulse, with a timeout, then returns one response per command on a valid/ready response channel.
- Keeps a saturating count of error responses.

Parameters:
ADDR_W, 32, width of command/memory address (memory flags addr >= 1024 as error)
DATA_W, 32, data width
DEPTH, 4, command FIFO entries (power of 2, >= 2)
TIMEOUT, 16, max cycles spent in WAIT before a timeout response (>= 2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  host command present
cmd_ready  out  1  FIFO can accept (= !full)
cmd_wr  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  command address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  host takes response
rsp_rdata  out  DATA_W  read data (0 for writes, errors, timeouts)
rsp_err  out  1  memory error or timeout
rsp_timeout  out  1  no mem_ready within TIMEOUT
mem_valid  out  1  request pulse to memory
mem_wr_rd  out  1  1=write, 0=read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory completion pulse
mem_rdata  in  DATA_W  memory read data
mem_error  in  1  memory address error
err_cnt  out  16  saturating count of rsp_err responses

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: all outputs 0 except cmd_ready=1. FIFO emptied, FSM=IDLE, timer=0, err_cnt=0.
- Reset mid-operation: the in-flight request and all queued commands are discarded and no response is produced.
- FIFO push on cmd_valid&&cmd_ready; pop only by FSM in IDLE.
- Simultaneous push and pop is legal at any occupancy except full. When full, cmd_ready=0 and the push is blocked.
- Pointers wrap modulo DEPTH.
- FSM, all outputs registered or state-decoded:
  - IDLE: if FIFO non-empty, pop the head into issue regs (mem_wr_rd/mem_addr/mem_wdata) and go to ISSUE.
  - ISSUE: mem_valid=1 for exactly this one cycle, then go to WAIT with timer cleared.
  - WAIT: mem_valid=0, timer increments each cycle.
    - If mem_ready=1: capture rsp_rdata=mem_rdata (reads with mem_error=0 only, else 0), rsp_err=mem_error, rsp_timeout=0, then go to RESP.
    - Else if timer==TIMEOUT-1: rsp_err=1, rsp_timeout=1, rsp_rdata=0, then go to RESP.
  - RESP: rsp_valid=1, payload held stable until rsp_ready. On the handshake edge: rsp_valid->0, err_cnt+=rsp_err (saturates at 16'hFFFF), go to IDLE.
- Only one request is ever outstanding.
- mem_addr/mem_wdata/mem_wr_rd hold their last values outside ISSUE.
- mem_ready is ignored outside WAIT, including a late pulse after a timeout.
- mem_ready and the timeout in the same cycle: mem_ready wins.
- Latency with empty FIFO and IDLE state: push at edge E0, mem_valid high E1–E2, memory ready E2–E3, rsp_valid high from E3. If rsp_ready is already 1, the response is consumed at E4 and the next command issues from E5.
- Back-to-back throughput: one command per 4 cycles with rsp_ready held high.
- Address width: mem_addr is passed through unchanged. Range checking is the memory's job; the controller only reports mem_error.

Test Plan:
- Reset then write addr=5 data=32'hDEADBEEF, then read addr=5 -> write rsp err=0 rdata=0; read rsp rdata=32'hDEADBEEF err=0; mem_valid high exactly 1 cycle per command.
- Read addr=1024 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0, err_cnt=1.
- Push 5 commands with rsp_ready=0 and DEPTH=4 -> cmd_ready=0 once 4 are queued plus 1 in flight; responses drain in order; no command lost or duplicated.
- Memory model never asserts mem_ready -> rsp_valid after TIMEOUT WAIT cycles with rsp_err=1, rsp_timeout=1; a late mem_ready pulse in IDLE is ignored.
- Assert rst while in WAIT with 2 queued -> outputs reset immediately, cmd_ready=1, no response emitted, err_cnt=0.
- Force err_cnt near 16'hFFFF with repeated bad-address reads -> err_cnt holds at 16'hFFFF.
